btn_event_scheduler: RTL
========================

BTN_EVENT_SCHEDULER -- requirements
Module: btn_event_scheduler

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 25000000, hold time before the first auto-repeat (500 ms at 50 MHz).
REQ-002 SHALL have parameter REPEAT_CYCLES, default 5000000, period between subsequent auto-repeats (100 ms).
REQ-003 SHALL have port clk  input  1  system clock, 50 MHz, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port btn_state  input  4  debounced level per button, bit i = button i.
REQ-006 SHALL have port btn_down  input  4  debounced one-cycle press pulse per button.
REQ-007 SHALL have port evt_valid  output  1  event FIFO head valid.
REQ-008 SHALL have port evt_ready  input  1  consumer accepts head when evt_valid & evt_ready.
REQ-009 SHALL have port evt_btn  output  2  button index of head event.
REQ-010 SHALL have port evt_repeat  output  1  head event type: 0 = press, 1 = auto-repeat.
REQ-011 SHALL have port overflow  output  1  one-cycle pulse when a request is dropped.
REQ-012 SHALL have port drop_cnt  output  8  saturating count of dropped requests.

Function
REQ-013 SHALL hold per-button pending bits pend_press[3:0] and pend_rpt[3:0], set on the edge that samples btn_down[i] or a repeat tick for button i.
REQ-014 SHALL, when a set request targets a pending bit already set and not granted that same edge, drop it: pulse overflow for 1 cycle and increment drop_cnt, saturating at 255; multiple drops in one cycle count as one.
REQ-015 SHALL grant at most one pending button per cycle, round-robin: search starts at rr_ptr, mod 4; after a grant to i, rr_ptr = i+1 mod 4.
REQ-016 SHALL, for a granted button with both bits set, enqueue the press first and leave pend_rpt set.
REQ-017 SHALL grant only when the FIFO is not full or is being popped that edge; a grant clears the corresponding pending bit and writes {btn, type}.
REQ-018 SHALL implement a 4-entry FIFO with 3-bit occupancy; evt_valid = occupancy != 0; evt_btn/evt_repeat driven from head register; pop on evt_valid & evt_ready.
REQ-019 SHALL accept simultaneous push and pop when full; occupancy unchanged, order preserved.
REQ-020 SHALL have latency: btn_down high at edge N, idle FIFO -> evt_valid high after edge N+1.
REQ-021 SHALL run one shared repeat engine, states IDLE, HOLD, REPEAT, with owner[1:0] and a cycle counter wide enough for max(HOLD_CYCLES, REPEAT_CYCLES).
REQ-022 SHALL, in IDLE with any btn_down bit high: owner = lowest such index, counter = 0, go to HOLD.
REQ-023 SHALL, in HOLD or REPEAT, on any btn_down bit: reassign owner to lowest such index, counter = 0, go to HOLD; this takes priority over tick and release.
REQ-024 SHALL, in HOLD or REPEAT with btn_state[owner] = 0, go to IDLE with counter = 0 and no tick.
REQ-025 SHALL, in HOLD with counter = HOLD_CYCLES-1: issue a repeat tick for owner, counter = 0, go to REPEAT; otherwise counter +1.
REQ-026 SHALL, in REPEAT with counter = REPEAT_CYCLES-1: issue a repeat tick, counter = 0, stay in REPEAT; otherwise counter +1.
REQ-027 SHALL keep evt_btn/evt_repeat stable while evt_valid & !evt_ready.

Reset
REQ-028 SHALL, on rst = 1 at a rising edge, clear all pending bits, FIFO (occupancy 0), rr_ptr = 0, engine to IDLE, owner = 0, counter = 0.
REQ-029 SHALL drive evt_valid = 0, evt_btn = 0, evt_repeat = 0, overflow = 0, drop_cnt = 0 during and after reset.
REQ-030 SHALL give rst priority over all inputs on the same edge; events in flight or queued at reset are discarded.

Verification
REQ-031 SHALL check single press, with HOLD_CYCLES = 8, REPEAT_CYCLES = 4, evt_ready = 1: btn_down = 0100 for 1 cycle, btn_state[2] high for 3 cycles -> exactly one event, btn = 2, repeat = 0, evt_valid 2 edges after the pulse.
REQ-032 SHALL check auto-repeat: hold btn_state[1] for 20 cycles after the press -> press, then repeat events 8, 12 and 16 cycles after the press; none after release.
REQ-033 SHALL check simultaneous presses: btn_down = 1111 in one cycle, evt_ready = 1 -> 4 press events, btn order 0, 1, 2, 3, one per cycle; next simultaneous burst resumes from rr_ptr.
REQ-034 SHALL check backpressure/overflow: evt_ready = 0, press buttons 0-3 then button 0 twice more -> FIFO holds 4 entries, one drop, overflow pulses once, drop_cnt = 1; drain -> order 0, 1, 2, 3.
REQ-035 SHALL check full push+pop: FIFO full, pend_press[3] set, evt_ready = 1 for one cycle -> occupancy stays 4, btn 3 becomes tail.
REQ-036 SHALL check reset mid-operation: rst in REPEAT with 3 entries queued -> evt_valid = 0, drop_cnt = 0 next cycle; no repeat tick until a new btn_down.

Source files
------------

// File: rtl/btn_event_scheduler.sv
// Four-button event scheduler: per-button pending requests, round-robin grant into a 4-deep
// event FIFO, and one shared hold/auto-repeat engine that follows the most recent press.
module btn_event_scheduler #(
  parameter int unsigned HOLD_CYCLES   = 25000000,
  parameter int unsigned REPEAT_CYCLES = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_state,
  input  logic [3:0] btn_down,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [1:0] evt_btn,
  output logic       evt_repeat,
  output logic       overflow,
  output logic [7:0] drop_cnt
);

  localparam int unsigned MaxCycles = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
  localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] RptLast  = CntW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StHold, StRepeat} state_e;

  state_e          r_state;
  logic [1:0]      r_owner;
  logic [CntW-1:0] r_cnt;
  logic [3:0]      r_pend_press, r_pend_rpt;
  logic [1:0]      r_rr;
  logic [2:0]      r_mem [4];
  logic [1:0]      r_wr, r_rd;
  logic [2:0]      r_count;
  logic            r_overflow;
  logic [7:0]      r_drop_cnt;

  logic [3:0] w_pend, w_clr_press, w_clr_rpt, w_req_rpt;
  logic [1:0] w_down_idx, w_gnt_idx, w_scan_idx;
  logic       w_last, w_tick, w_pop, w_gnt, w_gnt_rpt, w_drop;

  assign evt_valid  = (r_count != 3'd0);
  assign evt_btn    = r_mem[r_rd][2:1];
  assign evt_repeat = r_mem[r_rd][0];
  assign overflow   = r_overflow;
  assign drop_cnt   = r_drop_cnt;

  assign w_pop  = evt_valid & evt_ready;
  assign w_pend = r_pend_press | r_pend_rpt;
  assign w_last = (r_state == StHold) ? (r_cnt == HoldLast) : (r_cnt == RptLast);
  // A fresh press or a release both suppress the tick on this edge.
  assign w_tick = (r_state != StIdle) && (btn_down == 4'b0) && btn_state[r_owner] && w_last;

  always_comb begin
    w_down_idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (btn_down[k]) w_down_idx = 2'(k);
    end
  end

  // Scan downward so the first pending button at or after r_rr wins.
  always_comb begin
    w_gnt      = 1'b0;
    w_gnt_idx  = 2'd0;
    w_scan_idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      w_scan_idx = r_rr + 2'(k);
      if (w_pend[w_scan_idx]) begin
        w_gnt     = 1'b1;
        w_gnt_idx = w_scan_idx;
      end
    end
    if ((r_count == 3'd4) && !w_pop) w_gnt = 1'b0;
  end

  assign w_gnt_rpt   = !r_pend_press[w_gnt_idx];
  assign w_clr_press = (w_gnt && !w_gnt_rpt) ? (4'b0001 << w_gnt_idx) : 4'b0000;
  assign w_clr_rpt   = (w_gnt && w_gnt_rpt) ? (4'b0001 << w_gnt_idx) : 4'b0000;
  assign w_req_rpt   = w_tick ? (4'b0001 << r_owner) : 4'b0000;
  assign w_drop      = |((r_pend_press & ~w_clr_press & btn_down) |
                         (r_pend_rpt & ~w_clr_rpt & w_req_rpt));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_owner      <= 2'd0;
      r_cnt        <= '0;
      r_pend_press <= 4'b0;
      r_pend_rpt   <= 4'b0;
      r_rr         <= 2'd0;
      r_wr         <= 2'd0;
      r_rd         <= 2'd0;
      r_count      <= 3'd0;
      r_overflow   <= 1'b0;
      r_drop_cnt   <= 8'd0;
      for (int i = 0; i < 4; i++) r_mem[i] <= 3'd0;
    end else begin
      r_pend_press <= (r_pend_press & ~w_clr_press) | btn_down;
      r_pend_rpt   <= (r_pend_rpt & ~w_clr_rpt) | w_req_rpt;
      r_overflow   <= w_drop;
      if (w_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;

      if (w_gnt) begin
        r_mem[r_wr] <= {w_gnt_idx, w_gnt_rpt};
        r_wr        <= r_wr + 2'd1;
        r_rr        <= w_gnt_idx + 2'd1;
      end
      if (w_pop) r_rd <= r_rd + 2'd1;
      r_count <= r_count + 3'(w_gnt) - 3'(w_pop);

      case (r_state)
        StIdle: begin
          if (btn_down != 4'b0) begin
            r_owner <= w_down_idx;
            r_cnt   <= '0;
            r_state <= StHold;
          end
        end
        default: begin
          if (btn_down != 4'b0) begin
            r_owner <= w_down_idx;
            r_cnt   <= '0;
            r_state <= StHold;
          end else if (!btn_state[r_owner]) begin
            r_cnt   <= '0;
            r_state <= StIdle;
          end else if (w_last) begin
            r_cnt   <= '0;
            r_state <= StRepeat;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
      endcase
    end
  end

endmodule
